// File: rtl/nway_cache_if.sv
// nway_cache_if: CPU-side, memory-side and flush signals of the N-way cache.
// Modports: master = CPU + backing memory, slave = cache.
interface nway_cache_if #(
    parameter int s_offset = 5
) ();
    localparam int s_mask = 2 ** s_offset;
    localparam int s_line = 8 * s_mask;

    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [s_mask-1:0] mem_byte_enable;
    logic [s_line-1:0] mem_wdata;
    logic [s_line-1:0] mem_rdata;
    logic              mem_resp;

    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [s_line-1:0] pmem_wdata;
    logic [s_line-1:0] pmem_rdata;
    logic              pmem_resp;

    logic              flush;
    logic              flush_done;

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp,
        output flush,
        input  flush_done
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        input  flush,
        output flush_done
    );
endinterface

// File: rtl/nway_cache.sv
// nway_cache: N-way set-associative write-back cache, tree-PLRU, flush-all.
// Ports: clk, rst (sync, active-high), bus (nway_cache_if.slave).
module nway_cache #(
    parameter int s_offset = 5,
    parameter int s_index  = 4,
    parameter int num_ways = 4
) (
    input logic         clk,
    input logic         rst,
    nway_cache_if.slave bus
);
    localparam int s_tag    = 32 - s_offset - s_index;
    localparam int s_mask   = 2 ** s_offset;
    localparam int s_line   = 8 * s_mask;
    localparam int num_sets = 2 ** s_index;
    localparam int lg_ways  = $clog2(num_ways);
    localparam int cnt_w    = s_index + lg_ways;

    typedef enum logic [2:0] {
        IDLE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB
    } state_t;

    state_t r_state, w_next;

    logic [num_ways-1:0] r_valid [num_sets];
    logic [num_ways-1:0] r_dirty [num_sets];
    logic [num_ways-2:0] r_plru  [num_sets];
    logic [s_tag-1:0]    r_tag   [num_sets][num_ways];
    logic [s_line-1:0]   r_data  [num_sets][num_ways];
    logic [lg_ways-1:0]  r_victim;
    logic [cnt_w-1:0]    r_fcnt;

    logic [s_tag-1:0]   w_req_tag;
    logic [s_index-1:0] w_idx;
    logic [s_index-1:0] w_fset;
    logic [lg_ways-1:0] w_fway;
    logic               w_hit, w_inv;
    logic [lg_ways-1:0] w_hit_way, w_inv_way, w_victim;
    logic               w_touch, w_wr_hit, w_latch, w_alloc, w_fclean, w_finc;
    logic               w_mem_resp, w_pmem_read, w_pmem_write, w_flush_done;
    logic [31:0]        w_pmem_addr;
    logic [s_line-1:0]  w_pmem_wdata;

    // Each tree node bit points toward the less recently used half.
    // Node n (heap order, root=1) lives at bit n of a padded vector.
    function automatic logic [lg_ways-1:0] plru_victim(
        input logic [num_ways-2:0] b
    );
        logic [num_ways-1:0] t;
        logic [lg_ways-1:0]  n;
        logic [lg_ways-1:0]  w;
        logic                dir;
        t = {b, 1'b0};
        n = lg_ways'(1);
        w = '0;
        for (int l = 0; l < lg_ways; l++) begin
            dir = t[n];
            w   = (w << 1) | lg_ways'(dir);
            n   = (n << 1) | lg_ways'(dir);
        end
        return w;
    endfunction

    function automatic logic [num_ways-2:0] plru_touch(
        input logic [num_ways-2:0] b,
        input logic [lg_ways-1:0]  way
    );
        logic [num_ways-1:0] t;
        logic [lg_ways-1:0]  n;
        logic [lg_ways-1:0]  ws;
        logic                dir;
        t  = {b, 1'b0};
        n  = lg_ways'(1);
        ws = way;
        for (int l = 0; l < lg_ways; l++) begin
            dir  = ws[lg_ways-1];
            ws   = ws << 1;
            t[n] = ~dir;
            n    = (n << 1) | lg_ways'(dir);
        end
        return t[num_ways-1:1];
    endfunction

    assign w_req_tag = bus.mem_address[31 -: s_tag];
    assign w_idx     = bus.mem_address[s_offset +: s_index];
    assign w_fset    = r_fcnt[cnt_w-1 -: s_index];
    assign w_fway    = r_fcnt[lg_ways-1:0];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_inv     = 1'b0;
        w_inv_way = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_req_tag) begin
                w_hit     = 1'b1;
                w_hit_way = lg_ways'(w);
            end
            if (!r_valid[w_idx][w]) begin
                w_inv     = 1'b1;
                w_inv_way = lg_ways'(w);
            end
        end
        w_victim = w_inv ? w_inv_way : plru_victim(r_plru[w_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_mem_resp   = 1'b0;
        w_pmem_read  = 1'b0;
        w_pmem_write = 1'b0;
        w_flush_done = 1'b0;
        w_pmem_addr  = '0;
        w_pmem_wdata = r_data[w_idx][r_victim];
        w_touch      = 1'b0;
        w_wr_hit     = 1'b0;
        w_latch      = 1'b0;
        w_alloc      = 1'b0;
        w_fclean     = 1'b0;
        w_finc       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    if (w_hit) begin
                        w_mem_resp = 1'b1;
                        w_touch    = 1'b1;
                        w_wr_hit   = bus.mem_write;
                    end else begin
                        w_latch = 1'b1;
                        if (r_valid[w_idx][w_victim] &&
                            r_dirty[w_idx][w_victim])
                            w_next = WRITEBACK;
                        else
                            w_next = ALLOCATE;
                    end
                end else if (bus.flush) begin
                    w_next = FLUSH_SCAN;
                end
            end
            WRITEBACK: begin
                w_pmem_write = 1'b1;
                w_pmem_addr  = {r_tag[w_idx][r_victim], w_idx,
                                {s_offset{1'b0}}};
                if (bus.pmem_resp) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                w_pmem_read = 1'b1;
                w_pmem_addr = {bus.mem_address[31:s_offset],
                               {s_offset{1'b0}}};
                if (bus.pmem_resp) begin
                    w_alloc = 1'b1;
                    w_next  = IDLE;
                end
            end
            FLUSH_SCAN: begin
                if (r_valid[w_fset][w_fway] && r_dirty[w_fset][w_fway]) begin
                    w_next = FLUSH_WB;
                end else begin
                    w_finc = 1'b1;
                    if (&r_fcnt) begin
                        w_flush_done = 1'b1;
                        w_next       = IDLE;
                    end
                end
            end
            FLUSH_WB: begin
                w_pmem_write = 1'b1;
                w_pmem_addr  = {r_tag[w_fset][w_fway], w_fset,
                                {s_offset{1'b0}}};
                w_pmem_wdata = r_data[w_fset][w_fway];
                if (bus.pmem_resp) begin
                    w_fclean = 1'b1;
                    w_finc   = 1'b1;
                    if (&r_fcnt) begin
                        w_flush_done = 1'b1;
                        w_next       = IDLE;
                    end else begin
                        w_next = FLUSH_SCAN;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < num_sets; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
            r_fcnt <= '0;
        end else begin
            if (w_latch) r_victim <= w_victim;
            if (w_touch) r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
            if (w_wr_hit) begin
                r_dirty[w_idx][w_hit_way] <= 1'b1;
                for (int i = 0; i < s_mask; i++) begin
                    if (bus.mem_byte_enable[i])
                        r_data[w_idx][w_hit_way][8*i +: 8] <=
                            bus.mem_wdata[8*i +: 8];
                end
            end
            if (w_alloc) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
                r_tag[w_idx][r_victim]   <= w_req_tag;
                r_data[w_idx][r_victim]  <= bus.pmem_rdata;
            end
            if (w_fclean) r_dirty[w_fset][w_fway] <= 1'b0;
            if (w_finc)   r_fcnt <= r_fcnt + 1'b1;
        end
    end

    // Outputs are forced low while reset is asserted, so an in-flight
    // pmem transaction is dropped immediately.
    assign bus.mem_resp     = w_mem_resp & ~rst;
    assign bus.mem_rdata    = r_data[w_idx][w_hit_way];
    assign bus.pmem_read    = w_pmem_read & ~rst;
    assign bus.pmem_write   = w_pmem_write & ~rst;
    assign bus.pmem_address = w_pmem_addr;
    assign bus.pmem_wdata   = w_pmem_wdata;
    assign bus.flush_done   = w_flush_done & ~rst;
endmodule

// File: tb/tb_nway_cache.sv
// tb_nway_cache: random + directed bench for nway_cache with a
// timestamp-based LRU-tree reference model and a backing memory.
module tb_nway_cache;
    localparam int SO = 5;
    localparam int SI = 4;
    localparam int NW = 4;
    localparam int NS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nway_cache_if #(.s_offset(SO)) bus ();

    nway_cache #(.s_offset(SO), .s_index(SI), .num_ways(NW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc_now = 0;
    int last_rd_cyc = 0;
    int mem_lat = 0;
    int n_fd = 0;
    int n_both = 0;
    int wcnt = 0;

    logic [31:0]  rd_addr [$];
    logic [31:0]  wr_addr [$];
    logic [255:0] wr_data [$];
    logic [255:0] mm [logic [31:0]];

    bit           m_v   [NS][NW];
    bit           m_d   [NS][NW];
    logic [22:0]  m_t   [NS][NW];
    logic [255:0] m_dat [NS][NW];
    int           m_ts  [NS][NW];
    int           tnow = 0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] r;
        if (mm.exists(a)) return mm[a];
        for (int k = 0; k < 8; k++)
            r[32*k +: 32] = a ^ (32'h01010101 * 32'(k)) ^ 32'h5A5A0000;
        return r;
    endfunction

    function automatic logic [31:0] addr_of(input int tag, input int set);
        return {23'(tag), 4'(set), 5'b0};
    endfunction

    task automatic m_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_v[s][w]  = 1'b0;
                m_d[s][w]  = 1'b0;
                m_ts[s][w] = 0;
            end
    endtask

    // Walk the tree, always stepping into the half whose newest use is older.
    function automatic int m_plru(input int s);
        int lo, sz, h, ml, mr;
        lo = 0;
        sz = NW;
        while (sz > 1) begin
            h  = sz / 2;
            ml = 0;
            mr = 0;
            for (int i = 0; i < h; i++) begin
                if (m_ts[s][lo+i] > ml)   ml = m_ts[s][lo+i];
                if (m_ts[s][lo+h+i] > mr) mr = m_ts[s][lo+h+i];
            end
            if (ml > mr) lo = lo + h;
            sz = h;
        end
        return lo;
    endfunction

    always @(posedge clk) cyc_now <= cyc_now + 1;

    always @(negedge clk) begin
        if (bus.flush_done) n_fd <= n_fd + 1;
        if (bus.pmem_read && bus.pmem_write) n_both <= n_both + 1;
    end

    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                wcnt = 0;
            end else if (rst || !(bus.pmem_read || bus.pmem_write)) begin
                wcnt = 0;
            end else if (wcnt < mem_lat) begin
                wcnt++;
            end else begin
                bus.pmem_resp = 1'b1;
                if (bus.pmem_write) begin
                    wr_addr.push_back(bus.pmem_address);
                    wr_data.push_back(bus.pmem_wdata);
                end else begin
                    bus.pmem_rdata = mem_line(bus.pmem_address);
                    rd_addr.push_back(bus.pmem_address);
                    last_rd_cyc = cyc_now;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.flush     = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mem_resp", 256'(bus.mem_resp), 256'(0));
        check("rst_pmem_read", 256'(bus.pmem_read), 256'(0));
        check("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
        check("rst_flush_done", 256'(bus.flush_done), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [31:0] be, input logic [255:0] wd);
        int s, hw, v, nrd, nwr, n;
        logic [22:0]  t;
        bit           ewb;
        logic [31:0]  wba, la;
        logic [255:0] wbd;
        s   = int'(a[8:5]);
        t   = a[31:9];
        la  = {a[31:5], 5'b0};
        hw  = -1;
        ewb = 1'b0;
        wba = '0;
        wbd = '0;
        for (int w = 0; w < NW; w++)
            if (m_v[s][w] && m_t[s][w] == t) hw = w;
        v = hw;
        if (hw < 0) begin
            for (int w = NW - 1; w >= 0; w--)
                if (!m_v[s][w]) v = w;
            if (v < 0) v = m_plru(s);
            ewb = m_v[s][v] && m_d[s][v];
            wba = {m_t[s][v], 4'(s), 5'b0};
            wbd = m_dat[s][v];
        end
        nrd = rd_addr.size();
        nwr = wr_addr.size();
        @(negedge clk);
        bus.mem_address     = a;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        #1;
        n = 0;
        while (!bus.mem_resp && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("resp_seen", 256'(n < 300), 256'(1));
        if (hw < 0) begin
            if (ewb) mm[wba] = wbd;
            m_v[s][v]   = 1'b1;
            m_d[s][v]   = 1'b0;
            m_t[s][v]   = t;
            m_dat[s][v] = mem_line(la);
            check("miss_rd", 256'(rd_addr.size() - nrd), 256'(1));
            if (rd_addr.size() > nrd)
                check("miss_raddr", 256'(rd_addr[$]), 256'(la));
            check("miss_lat", 256'(cyc_now - last_rd_cyc), 256'(1));
        end else begin
            check("hit_lat", 256'(n), 256'(0));
            check("hit_nord", 256'(rd_addr.size() - nrd), 256'(0));
        end
        check("wb_cnt", 256'(wr_addr.size() - nwr), 256'(ewb));
        if (ewb && wr_addr.size() > nwr) begin
            check("wb_addr", 256'(wr_addr[nwr]), 256'(wba));
            check("wb_data", wr_data[nwr], wbd);
        end
        tnow++;
        m_ts[s][v] = tnow;
        if (wr) begin
            for (int i = 0; i < 32; i++)
                if (be[i]) m_dat[s][v][8*i +: 8] = wd[8*i +: 8];
            m_d[s][v] = 1'b1;
        end else begin
            check("rdata", bus.mem_rdata, m_dat[s][v]);
        end
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic do_flush();
        logic [31:0]  ea [$];
        logic [255:0] ed [$];
        int nwr, nfd, n;
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++)
                if (m_v[s][w] && m_d[s][w]) begin
                    ea.push_back({m_t[s][w], 4'(s), 5'b0});
                    ed.push_back(m_dat[s][w]);
                    mm[{m_t[s][w], 4'(s), 5'b0}] = m_dat[s][w];
                    m_d[s][w] = 1'b0;
                end
        nwr = wr_addr.size();
        nfd = n_fd;
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        n = 0;
        while (n_fd == nfd && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("flush_seen", 256'(n < 3000), 256'(1));
        repeat (3) @(negedge clk);
        check("flush_done_cnt", 256'(n_fd - nfd), 256'(1));
        check("flush_wb_cnt", 256'(wr_addr.size() - nwr), 256'(ea.size()));
        for (int i = 0; i < ea.size(); i++) begin
            if (nwr + i < wr_addr.size()) begin
                check("flush_addr", 256'(wr_addr[nwr+i]), 256'(ea[i]));
                check("flush_data", wr_data[nwr+i], ed[i]);
            end
        end
    endtask

    task automatic rand_access();
        logic [31:0]  a, be;
        logic [255:0] wd;
        bit           wr, rd;
        a  = addr_of($urandom_range(0, 5), $urandom_range(0, 3)) |
             32'($urandom_range(0, 31));
        be = $urandom;
        for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom;
        wr = 1'($urandom_range(0, 1));
        rd = !wr || 1'($urandom_range(0, 1));
        mem_lat = $urandom_range(0, 3);
        access(a, rd, wr, be, wd);
    endtask

    initial begin
        logic [255:0] wd;
        int n;
        bus.mem_address     = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;
        bus.flush           = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        mem_lat = 2;
        access(32'h0000_1040, 1'b1, 1'b0, '0, '0);
        wd = {{7{32'h1234_5678}}, 32'hDEAD_BEEF};
        access(32'h0000_1040, 1'b0, 1'b1, 32'h0000_000F, wd);
        access(32'h0000_1040, 1'b1, 1'b0, '0, '0);
        check("req037_word", 256'(bus.mem_rdata[31:0]), 256'(32'hDEAD_BEEF));

        mem_lat = 1;
        access(addr_of('h101, 2), 1'b0, 1'b1, 32'hFFFF_FFFF, {8{32'hCAFE_F00D}});
        access(addr_of('h100, 2), 1'b1, 1'b0, '0, '0);
        access(addr_of('h102, 2), 1'b1, 1'b0, '0, '0);
        access(addr_of('h103, 2), 1'b1, 1'b0, '0, '0);
        access(addr_of('h100, 2), 1'b1, 1'b0, '0, '0);
        access(addr_of('h104, 2), 1'b1, 1'b0, '0, '0);
        access(addr_of('h105, 2), 1'b1, 1'b1, 32'h0000_00F0, {8{32'h0BAD_0BAD}});
        access(addr_of('h100, 2), 1'b1, 1'b0, '0, '0);

        do_reset();
        for (int i = 0; i < 3; i++)
            access(addr_of(7, 1 + 4 * i), 1'b0, 1'b1, 32'h00FF_00FF,
                   {8{32'(i) ^ 32'hA5A5_0000}});
        do_flush();
        for (int i = 0; i < 3; i++)
            access(addr_of(7, 1 + 4 * i), 1'b1, 1'b0, '0, '0);

        for (int i = 0; i < 250; i++) rand_access();
        mem_lat = 1;
        do_flush();

        mem_lat = 30;
        @(negedge clk);
        bus.mem_address = addr_of(9, 3);
        bus.mem_read    = 1'b1;
        bus.mem_write   = 1'b0;
        n = 0;
        while (!bus.pmem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("alloc_seen", 256'(bus.pmem_read), 256'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_alloc_pread", 256'(bus.pmem_read), 256'(0));
        check("rst_alloc_pwrite", 256'(bus.pmem_write), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.mem_read = 1'b0;
        m_reset();
        mem_lat = 1;
        access(addr_of(9, 3), 1'b1, 1'b0, '0, '0);
        access(32'h0000_1040, 1'b1, 1'b0, '0, '0);

        check("rw_exclusive", 256'(n_both), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
